branch_hazard_ctrl: RTL and testbench
=====================================

# branch_hazard_ctrl

Pipeline control sequencer that owns the branch-resolution decision (`pc_sel`) and all pipeline-register write/flush strobes. Sits beside the EX stage: it turns the EX-stage branch/zero outcome into a PC redirect plus wrong-path flush, detects load-use hazards against the ID stage, and holds the front end while instruction memory is not ready. It also keeps two saturating performance counters for branch and stall analysis.

## Interface
- `CNT_W`, 16, width of the performance counters
- `REG_W`, 5, register-specifier width
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `ex_valid`  in  1  EX stage holds a real instruction, not a bubble
- `ex_branch`  in  1  EX instruction is a conditional branch
- `ex_zero`  in  1  ALU zero flag for the EX instruction
- `ex_jump`  in  1  EX instruction is an unconditional jump
- `idex_mem_read`  in  1  ID/EX instruction is a load
- `idex_rd`  in  REG_W  destination register of the ID/EX instruction
- `ifid_valid`  in  1  IF/ID holds a real instruction
- `ifid_rs`, `ifid_rt`  in  REG_W each  source registers of the IF/ID instruction
- `imem_ready`  in  1  instruction memory returns a fetch this cycle
- `pc_sel`  out  1  1 = load branch/jump target into PC
- `pc_write`  out  1  PC register enable
- `ifid_write`  out  1  IF/ID enable
- `ifid_flush`  out  1  load NOP into IF/ID; overrides `ifid_write`
- `idex_flush`  out  1  load NOP into ID/EX
- `ex_hold`  out  1  freeze EX/MEM inputs; EX instruction is re-presented
- `taken_cnt`  out  CNT_W  count of redirects issued
- `stall_cnt`  out  CNT_W  count of cycles with `pc_write`=0

## Operation
- `taken` = `ex_valid` & ((`ex_branch` & `ex_zero`) | `ex_jump`).
- `lu_haz` = `idex_mem_read` & `ifid_valid` & `idex_rd`≠0 & (`idex_rd`==`ifid_rs` | `idex_rd`==`ifid_rt`).
- FSM states are RUN, LU_STALL and REDIR_WAIT. Reset state is RUN.
- Outputs are Mealy, decoded combinationally from the state and the current inputs. Default output values: `pc_write`=1, `ifid_write`=1, and all other strobes 0.
- RUN, priority order:
  1. `taken` & `imem_ready`: assert `pc_sel`, `ifid_flush` and `idex_flush`; stay in RUN.
  2. `taken` & !`imem_ready`: assert `pc_write`=0, `ifid_write`=0 and `ex_hold`=1; go to REDIR_WAIT.
  3. `lu_haz`: assert `pc_write`=0, `ifid_write`=0 and `idex_flush`=1; go to LU_STALL.
  4. !`imem_ready`: assert `pc_write`=0 and `ifid_flush`=1 (bubble enters ID); stay in RUN.
- LU_STALL: hazard detection is not re-evaluated this cycle. All other rules are as in RUN, and `taken` still has priority. Return to RUN unless rule 2 fires.
- REDIR_WAIT:
  - While !`imem_ready`: hold the same outputs as rule 2.
  - On `imem_ready`: assert `pc_sel`, `ifid_flush`, `idex_flush` and `ex_hold`=0; go to RUN.
- Counters saturate at all-ones and never wrap.
  - `taken_cnt` increments in every cycle where `pc_sel`=1.
  - `stall_cnt` increments in every cycle where `pc_write`=0.
- While `rst_n`=0, outputs are forced regardless of inputs: `pc_sel`=0, `pc_write`=0, `ifid_write`=0, `ifid_flush`=1, `idex_flush`=1, `ex_hold`=0, counters=0.
- Reset asserted mid-REDIR_WAIT drops the pending redirect; fetch restarts from the reset PC.

## Timing
- Redirect latency is 0 cycles: `pc_sel` is asserted in the same cycle as `taken` & `imem_ready`. The target PC is taken on the following edge.
- Redirect penalty is exactly 2 squashed instructions (IF/ID and ID/EX contents) when `imem_ready` stays high.
- A load-use hazard costs exactly 1 bubble cycle.
- REDIR_WAIT lasts N+1 cycles for N consecutive low-`imem_ready` cycles.
- The FSM state and the counters are the only flops. Both use the asynchronous `rst_n` clear.

## Structure
- Shared control package holds:
  - the state enum (RUN, LU_STALL, REDIR_WAIT);
  - the `REG_W` constant;
  - the NOP encoding used by flushed registers.
- One sub-module, `sat_counter` (parameter `CNT_W`, inputs `inc`, `clk`, `rst_n`), instantiated twice.
- Hazard and taken detection stay inline.

## Test plan
- Reset: hold `rst_n`=0 with random inputs → `pc_sel`=0, `pc_write`=0, both flushes=1, counters=0; first cycle after release is in RUN with default strobes.
- Taken branch (`ex_branch`=1, `ex_zero`=1, `imem_ready`=1) → in the same cycle `pc_sel`=1 and both flushes=1; `taken_cnt` goes 0→1. With `ex_zero`=0 → no strobes asserted.
- Load-use: `idex_mem_read`=1, `idex_rd`=3, `ifid_rs`=3 → one cycle of `pc_write`=0 and `idex_flush`=1, then normal flow; `stall_cnt`=1. Repeat with `idex_rd`=0 → no stall.
- Branch during fetch stall: `taken`=1 with `imem_ready`=0 for 3 cycles → `ex_hold`=1 for 3 cycles; `pc_sel` pulses in cycle 4; `stall_cnt`=3.
- Simultaneous `taken` and `lu_haz` → redirect wins: `pc_sel`=1, no LU_STALL entered.
- Saturation: with `CNT_W`=4, drive 20 taken branches → `taken_cnt` holds at 15.

Source files
------------

// File: rtl/branch_hazard_ctrl_pkg.sv
// Shared pipeline-control definitions: sequencer states, register-specifier
// width and the instruction word loaded into flushed pipeline registers.
package branch_hazard_ctrl_pkg;

    localparam int unsigned REG_W   = 5;
    localparam int unsigned INSTR_W = 32;

    // All-zero word decodes as a no-op (sll r0, r0, 0)
    localparam logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(0);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LU_STALL   = 2'd1,
        ST_REDIR_WAIT = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/branch_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the pipeline performance statistics.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/branch_hazard_ctrl.sv
// EX-stage control sequencer: branch redirect/flush, load-use stall, fetch-miss
// hold and saturating taken/stall performance counters.
module branch_hazard_ctrl
    import branch_hazard_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_ex_valid,
    input  logic             i_ex_branch,
    input  logic             i_ex_zero,
    input  logic             i_ex_jump,
    input  logic             i_idex_mem_read,
    input  logic [REG_W-1:0] i_idex_rd,
    input  logic             i_ifid_valid,
    input  logic [REG_W-1:0] i_ifid_rs,
    input  logic [REG_W-1:0] i_ifid_rt,
    input  logic             i_imem_ready,
    output logic             o_pc_sel,
    output logic             o_pc_write,
    output logic             o_ifid_write,
    output logic             o_ifid_flush,
    output logic             o_idex_flush,
    output logic             o_ex_hold,
    output logic [CNT_W-1:0] o_taken_cnt,
    output logic [CNT_W-1:0] o_stall_cnt
);

    ctrl_state_e r_state;
    ctrl_state_e w_state_nxt;
    logic        w_taken;
    logic        w_lu_haz;

    assign w_taken  = i_ex_valid & ((i_ex_branch & i_ex_zero) | i_ex_jump);
    assign w_lu_haz = i_idex_mem_read & i_ifid_valid & (i_idex_rd != REG_W'(0)) &
                      ((i_idex_rd == i_ifid_rs) | (i_idex_rd == i_ifid_rt));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Mealy decode; LU_STALL shares RUN's rules but skips hazard detection
    always_comb begin
        w_state_nxt  = r_state;
        o_pc_sel     = 1'b0;
        o_pc_write   = 1'b1;
        o_ifid_write = 1'b1;
        o_ifid_flush = 1'b0;
        o_idex_flush = 1'b0;
        o_ex_hold    = 1'b0;

        case (r_state)
            ST_RUN, ST_LU_STALL: begin
                w_state_nxt = ST_RUN;
                if (w_taken && i_imem_ready) begin
                    o_pc_sel     = 1'b1;
                    o_ifid_flush = 1'b1;
                    o_idex_flush = 1'b1;
                end else if (w_taken) begin
                    o_pc_write   = 1'b0;
                    o_ifid_write = 1'b0;
                    o_ex_hold    = 1'b1;
                    w_state_nxt  = ST_REDIR_WAIT;
                end else if (w_lu_haz && (r_state == ST_RUN)) begin
                    o_pc_write   = 1'b0;
                    o_ifid_write = 1'b0;
                    o_idex_flush = 1'b1;
                    w_state_nxt  = ST_LU_STALL;
                end else if (!i_imem_ready) begin
                    o_pc_write   = 1'b0;
                    o_ifid_flush = 1'b1;
                end
            end
            ST_REDIR_WAIT: begin
                if (i_imem_ready) begin
                    o_pc_sel     = 1'b1;
                    o_ifid_flush = 1'b1;
                    o_idex_flush = 1'b1;
                    w_state_nxt  = ST_RUN;
                end else begin
                    o_pc_write   = 1'b0;
                    o_ifid_write = 1'b0;
                    o_ex_hold    = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase

        // Reset forces a quiescent, flushed pipeline regardless of inputs
        if (!rst_n) begin
            o_pc_sel     = 1'b0;
            o_pc_write   = 1'b0;
            o_ifid_write = 1'b0;
            o_ifid_flush = 1'b1;
            o_idex_flush = 1'b1;
            o_ex_hold    = 1'b0;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (o_pc_sel),
        .o_count (o_taken_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (~o_pc_write),
        .o_count (o_stall_cnt)
    );

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Directed-vector bench for branch_hazard_ctrl; counters built 4 bits wide so
// saturation is reachable in a short run.
module tb_branch_hazard_ctrl;

    localparam int unsigned CNT_W = 4;
    localparam int unsigned REG_W = 5;

    // strobe vector order: {pc_sel, pc_write, ifid_write, ifid_flush, idex_flush, ex_hold}
    localparam logic [5:0] S_DEF   = 6'b011000;
    localparam logic [5:0] S_RST   = 6'b000110;
    localparam logic [5:0] S_TAKEN = 6'b111110;
    localparam logic [5:0] S_RWAIT = 6'b000001;
    localparam logic [5:0] S_LU    = 6'b000010;
    localparam logic [5:0] S_IMISS = 6'b001100;

    logic             clk;
    logic             rst_n;
    logic             ex_valid, ex_branch, ex_zero, ex_jump;
    logic             idex_mem_read;
    logic [REG_W-1:0] idex_rd;
    logic             ifid_valid;
    logic [REG_W-1:0] ifid_rs, ifid_rt;
    logic             imem_ready;
    logic             pc_sel, pc_write, ifid_write, ifid_flush, idex_flush, ex_hold;
    logic [CNT_W-1:0] taken_cnt, stall_cnt;
    logic [5:0]       strb;

    int n_vec;
    int n_err;

    branch_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_ex_valid      (ex_valid),
        .i_ex_branch     (ex_branch),
        .i_ex_zero       (ex_zero),
        .i_ex_jump       (ex_jump),
        .i_idex_mem_read (idex_mem_read),
        .i_idex_rd       (idex_rd),
        .i_ifid_valid    (ifid_valid),
        .i_ifid_rs       (ifid_rs),
        .i_ifid_rt       (ifid_rt),
        .i_imem_ready    (imem_ready),
        .o_pc_sel        (pc_sel),
        .o_pc_write      (pc_write),
        .o_ifid_write    (ifid_write),
        .o_ifid_flush    (ifid_flush),
        .o_idex_flush    (idex_flush),
        .o_ex_hold       (ex_hold),
        .o_taken_cnt     (taken_cnt),
        .o_stall_cnt     (stall_cnt)
    );

    assign strb = {pc_sel, pc_write, ifid_write, ifid_flush, idex_flush, ex_hold};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs are then driven and outputs sampled mid-cycle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ex_valid = 1'b0; ex_branch = 1'b0; ex_zero = 1'b0; ex_jump = 1'b0;
        idex_mem_read = 1'b0; idex_rd = '0;
        ifid_valid = 1'b0; ifid_rs = '0; ifid_rt = '0;
        imem_ready = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        idle();
        rst_n = 1'b0;

        // reset with random inputs
        for (int i = 0; i < 4; i++) begin
            tick();
            {ex_valid, ex_branch, ex_zero, ex_jump, idex_mem_read, ifid_valid, imem_ready} = 7'($urandom);
            idex_rd = REG_W'($urandom);
            ifid_rs = idex_rd;
            ifid_rt = REG_W'($urandom);
            #1;
            chk("rst_strb", 32'(strb), 32'(S_RST));
            chk("rst_taken_cnt", 32'(taken_cnt), 32'd0);
            chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        end
        idle();
        rst_n = 1'b1;
        #1;
        chk("post_rst_def", 32'(strb), 32'(S_DEF));

        // taken branch, same-cycle redirect
        tick();
        ex_valid = 1'b1; ex_branch = 1'b1; ex_zero = 1'b1;
        #1;
        chk("br_taken_strb", 32'(strb), 32'(S_TAKEN));
        tick();
        chk("br_taken_cnt", 32'(taken_cnt), 32'd1);
        ex_zero = 1'b0;
        #1;
        chk("br_not_taken", 32'(strb), 32'(S_DEF));
        tick();
        chk("br_not_taken_cnt", 32'(taken_cnt), 32'd1);
        chk("br_stall_cnt", 32'(stall_cnt), 32'd0);

        // jump, and jump in a bubble
        ex_branch = 1'b0; ex_jump = 1'b1;
        #1;
        chk("jump_taken", 32'(strb), 32'(S_TAKEN));
        ex_valid = 1'b0;
        #1;
        chk("jump_bubble", 32'(strb), 32'(S_DEF));
        idle();

        // load-use via rs: exactly one bubble
        do_reset();
        idex_mem_read = 1'b1; idex_rd = 5'd3; ifid_valid = 1'b1; ifid_rs = 5'd3; ifid_rt = 5'd9;
        #1;
        chk("lu_rs_strb", 32'(strb), 32'(S_LU));
        tick();
        chk("lu_second_cycle", 32'(strb), 32'(S_DEF));
        tick();
        chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
        idle();
        #1;
        chk("lu_after", 32'(strb), 32'(S_DEF));

        // r0 never creates a hazard; rt match does
        idex_mem_read = 1'b1; idex_rd = 5'd0; ifid_valid = 1'b1; ifid_rs = 5'd0; ifid_rt = 5'd0;
        #1;
        chk("lu_r0_none", 32'(strb), 32'(S_DEF));
        tick();
        chk("lu_r0_stall_cnt", 32'(stall_cnt), 32'd1);
        idex_rd = 5'd7; ifid_rs = 5'd1; ifid_rt = 5'd7;
        #1;
        chk("lu_rt_strb", 32'(strb), 32'(S_LU));
        ifid_valid = 1'b0;
        #1;
        chk("lu_ifid_invalid", 32'(strb), 32'(S_DEF));
        idle();

        // plain fetch miss inserts a bubble into ID
        tick();
        imem_ready = 1'b0;
        #1;
        chk("imiss_strb", 32'(strb), 32'(S_IMISS));
        idle();

        // branch during a 3-cycle fetch stall
        do_reset();
        ex_valid = 1'b1; ex_branch = 1'b1; ex_zero = 1'b1; imem_ready = 1'b0;
        #1;
        chk("rw_c1", 32'(strb), 32'(S_RWAIT));
        tick();
        chk("rw_c2", 32'(strb), 32'(S_RWAIT));
        tick();
        chk("rw_c3", 32'(strb), 32'(S_RWAIT));
        tick();
        imem_ready = 1'b1;
        #1;
        chk("rw_c4_redirect", 32'(strb), 32'(S_TAKEN));
        tick();
        chk("rw_stall_cnt", 32'(stall_cnt), 32'd3);
        chk("rw_taken_cnt", 32'(taken_cnt), 32'd1);
        idle();
        #1;
        chk("rw_back_run", 32'(strb), 32'(S_DEF));

        // reset mid-REDIR_WAIT drops the pending redirect
        ex_valid = 1'b1; ex_jump = 1'b1; imem_ready = 1'b0;
        tick();
        chk("rw_pending", 32'(strb), 32'(S_RWAIT));
        rst_n = 1'b0;
        #1;
        chk("rw_async_rst", 32'(strb), 32'(S_RST));
        chk("rw_async_rst_cnt", 32'(stall_cnt), 32'd0);
        idle();
        tick();
        rst_n = 1'b1;
        #1;
        chk("rw_dropped", 32'(strb), 32'(S_DEF));

        // taken and load-use together: redirect wins, no LU_STALL
        tick();
        ex_valid = 1'b1; ex_branch = 1'b1; ex_zero = 1'b1;
        idex_mem_read = 1'b1; idex_rd = 5'd4; ifid_valid = 1'b1; ifid_rs = 5'd4;
        #1;
        chk("both_redirect", 32'(strb), 32'(S_TAKEN));
        tick();
        ex_valid = 1'b0;
        #1;
        chk("both_still_run", 32'(strb), 32'(S_LU));
        tick();
        chk("both_lu_stall", 32'(strb), 32'(S_DEF));
        idle();

        // saturation of the 4-bit taken counter
        do_reset();
        ex_valid = 1'b1; ex_branch = 1'b1; ex_zero = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 14) chk("sat_at_15", 32'(taken_cnt), 32'd15);
        end
        chk("sat_hold_15", 32'(taken_cnt), 32'd15);
        chk("sat_stall_0", 32'(stall_cnt), 32'd0);
        idle();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
